fft_iter_addr_gen: RTL

FFT_ITER_ADDR_GEN -- requirements
Module: fft_iter_addr_gen

---
 rtl/fft_iter_addr_gen_pkg.sv | 18 +
 rtl/fft_addr_map.sv | 44 ++++
 rtl/fft_iter_addr_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/fft_iter_addr_gen_pkg.sv
// Shared FFT constants for the iterative radix-2 address generator.
// Holds the default geometry (layers, butterflies per layer, counter widths)
// and the RAM address width derived from the butterfly counter width.
package fft_iter_addr_gen_pkg;

  localparam int LAYERS_DEF      = 5;
  localparam int BUTTERFLYES_DEF = 16;
  localparam int LAY_WL_DEF      = 3;
  localparam int BUTT_WL_DEF     = 4;

  // A RAM address spans N = 2 * BUTTERFLYES points, one bit wider than b.
  function automatic int addr_wl(input int butt_wl);
    return butt_wl + 1;
  endfunction

  localparam int ADDR_WL_DEF = addr_wl(BUTT_WL_DEF);

endpackage

// File: rtl/fft_addr_map.sv
// Combinational butterfly address mapping for one radix-2 layer.
// Ports:
//   b      : butterfly index within the layer
//   s      : layer index
//   addr_a : b with a 0 inserted at bit s (upper operand)
//   addr_b : addr_a with bit s set (lower operand)
//   w_addr : (b mod 2^s) << (LAYERS-1-s), truncated to ButtWL bits
module fft_addr_map
  import fft_iter_addr_gen_pkg::*;
#(
  parameter int LAYERS = LAYERS_DEF,
  parameter int LayWL  = LAY_WL_DEF,
  parameter int ButtWL = BUTT_WL_DEF
) (
  input  logic [ButtWL-1:0] b,
  input  logic [LayWL-1:0]  s,
  output logic [ButtWL:0]   addr_a,
  output logic [ButtWL:0]   addr_b,
  output logic [ButtWL-1:0] w_addr
);

  localparam int AW = addr_wl(ButtWL);

  logic [AW-1:0] low;
  logic [AW-1:0] bx;
  int            s_i;
  int            sh;

  always_comb begin
    s_i = int'(s);
    // Mask of the bits below position s; they pass through unshifted.
    low = '0;
    for (int i = 0; i < AW; i++) begin
      if (i < s_i) low[i] = 1'b1;
    end
    bx     = {1'b0, b};
    addr_a = ((bx & ~low) << 1) | (bx & low);
    addr_b = addr_a | (AW'(1) << s);
    // Guard keeps the shift non-negative should s ever exceed LAYERS-1.
    sh     = (s_i < LAYERS) ? (LAYERS - 1 - s_i) : 0;
    w_addr = (b & low[ButtWL-1:0]) << sh;
  end

endmodule

// File: rtl/fft_iter_addr_gen.sv
// Iterative radix-2 FFT address generator.
// Tracks butterfly index b and layer index s and produces registered RAM
// operand addresses and the twiddle ROM index for the current butterfly.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset
//   EN            : global enable; when low all state holds and DONE is low
//   START         : begin a transform (b = s = 0)
//   ADDR_EN       : butterfly write strobe; advances b
//   LAY_EN        : layer advance strobe; advances s, clears b
//   ADDR_A/ADDR_B : upper/lower operand RAM addresses
//   W_ADDR        : twiddle ROM index
//   LAST_LAY      : current layer is LAYERS-1
//   DONE          : one-cycle pulse after the final write of the final layer
module fft_iter_addr_gen
  import fft_iter_addr_gen_pkg::*;
#(
  parameter int LAYERS      = LAYERS_DEF,
  parameter int BUTTERFLYES = BUTTERFLYES_DEF,
  parameter int LayWL       = LAY_WL_DEF,
  parameter int ButtWL      = BUTT_WL_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic              ADDR_EN,
  input  logic              LAY_EN,
  output logic [ButtWL:0]   ADDR_A,
  output logic [ButtWL:0]   ADDR_B,
  output logic [ButtWL-1:0] W_ADDR,
  output logic              LAST_LAY,
  output logic              DONE
);

  localparam int                AW     = addr_wl(ButtWL);
  localparam logic [LayWL-1:0]  S_LAST = LayWL'(LAYERS - 1);
  localparam logic [ButtWL-1:0] B_LAST = ButtWL'(BUTTERFLYES - 1);

  logic [ButtWL-1:0] b_cnt;
  logic [LayWL-1:0]  s_cnt;
  logic [AW-1:0]     a_p0;
  logic [AW-1:0]     b_p0;
  logic [ButtWL-1:0] w_p0;

  fft_addr_map #(
    .LAYERS (LAYERS),
    .LayWL  (LayWL),
    .ButtWL (ButtWL)
  ) u_map (
    .b      (b_cnt),
    .s      (s_cnt),
    .addr_a (a_p0),
    .addr_b (b_p0),
    .w_addr (w_p0)
  );

  // Stage p0 -> outputs: addresses registered from the b/s held before the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      b_cnt    <= '0;
      s_cnt    <= '0;
      ADDR_A   <= '0;
      ADDR_B   <= AW'(1);
      W_ADDR   <= '0;
      LAST_LAY <= 1'b0;
      DONE     <= 1'b0;
    end else if (!EN) begin
      DONE <= 1'b0;
    end else begin
      ADDR_A   <= a_p0;
      ADDR_B   <= b_p0;
      W_ADDR   <= w_p0;
      LAST_LAY <= (s_cnt == S_LAST);
      DONE     <= 1'b0;
      if (START) begin
        b_cnt <= '0;
        s_cnt <= '0;
      end else if (LAY_EN) begin
        // Layer strobe wins over a coincident butterfly strobe; s saturates.
        b_cnt <= '0;
        if (s_cnt != S_LAST) s_cnt <= s_cnt + 1'b1;
      end else if (ADDR_EN) begin
        if (b_cnt == B_LAST) begin
          b_cnt <= '0;
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            DONE  <= 1'b1;
          end
        end else begin
          b_cnt <= b_cnt + 1'b1;
        end
      end
    end
  end

endmodule
